// File: rtl/pulse_period_meter.sv
// Pulse period meter: measures clk cycles between rising edges of tick_in, tracks lock and signal loss.
// Optional input synchronizer enabled by defining PULSE_PERIOD_METER_SYNC_EN.
module pulse_period_meter #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned EXPECTED = 1000000,
    parameter int unsigned TOL      = 1000,
    parameter int unsigned TIMEOUT  = 2000000,
    parameter int unsigned LOCK_N   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             clear,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             stalled
);

    localparam int unsigned BOUND_W = WIDTH + 1;
    localparam int unsigned GOOD_W  = 4;

    // Bounds carry one extra bit so EXPECTED+TOL cannot wrap; the low bound clamps at zero.
    localparam logic [WIDTH:0] LO_BOUND =
        (EXPECTED > TOL) ? BOUND_W'(EXPECTED - TOL) : '0;
    localparam logic [WIDTH:0] HI_BOUND = BOUND_W'(EXPECTED) + BOUND_W'(TOL);

    localparam logic [WIDTH-1:0]  CNT_LAST    = WIDTH'(TIMEOUT - 1);
    localparam logic [GOOD_W-1:0] LOCK_TARGET = GOOD_W'(LOCK_N);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOST    = 2'd2
    } state_t;

    state_t state, state_next;

    logic              s_in;
    logic              s;
    logic              s_prev;
    logic              tick_edge;

    logic [WIDTH-1:0]  cnt, cnt_next;
    logic [WIDTH-1:0]  period_next;
    logic              period_valid_next;
    logic [GOOD_W-1:0] good_cnt, good_cnt_next;
    logic              locked_next;
    logic              stalled_next;

    logic [WIDTH-1:0]  period_cand;
    logic              in_range;
    logic [GOOD_W-1:0] good_inc;

`ifdef PULSE_PERIOD_METER_SYNC_EN
    logic sync_a;
    logic sync_b;

    // Two-flop synchronizer for an asynchronous tick source.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= tick_in;
            sync_b <= sync_a;
        end
    end

    assign s_in = sync_b;
`else
    assign s_in = tick_in;
`endif

    // Input register and previous-sample register for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s      <= 1'b0;
            s_prev <= 1'b0;
        end else begin
            s      <= s_in;
            s_prev <= s;
        end
    end

    assign tick_edge   = s & ~s_prev;
    assign period_cand = cnt + WIDTH'(1);
    assign in_range    = ({1'b0, period_cand} >= LO_BOUND) &&
                         ({1'b0, period_cand} <= HI_BOUND);
    assign good_inc    = (good_cnt == LOCK_TARGET) ? good_cnt : good_cnt + GOOD_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath update; clear overrides any edge or timeout.
    always_comb begin
        state_next        = state;
        cnt_next          = cnt;
        period_next       = period;
        period_valid_next = 1'b0;
        good_cnt_next     = good_cnt;
        locked_next       = locked;
        stalled_next      = stalled;

        if (clear) begin
            state_next    = IDLE;
            cnt_next      = '0;
            period_next   = '0;
            good_cnt_next = '0;
            locked_next   = 1'b0;
            stalled_next  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_next = '0;
                    if (tick_edge) begin
                        state_next = MEASURE;
                    end
                end

                MEASURE: begin
                    if (tick_edge) begin
                        period_next       = period_cand;
                        period_valid_next = 1'b1;
                        cnt_next          = '0;
                        if (in_range) begin
                            good_cnt_next = good_inc;
                            locked_next   = (good_inc == LOCK_TARGET);
                        end else begin
                            good_cnt_next = '0;
                            locked_next   = 1'b0;
                        end
                    end else if (cnt == CNT_LAST) begin
                        // Signal lost: lock history is no longer meaningful.
                        state_next    = LOST;
                        cnt_next      = '0;
                        stalled_next  = 1'b1;
                        locked_next   = 1'b0;
                        good_cnt_next = '0;
                    end else begin
                        cnt_next = cnt + WIDTH'(1);
                    end
                end

                LOST: begin
                    cnt_next = '0;
                    if (tick_edge) begin
                        state_next = MEASURE;
                    end
                end

                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            good_cnt     <= '0;
            locked       <= 1'b0;
            stalled      <= 1'b0;
        end else begin
            cnt          <= cnt_next;
            period       <= period_next;
            period_valid <= period_valid_next;
            good_cnt     <= good_cnt_next;
            locked       <= locked_next;
            stalled      <= stalled_next;
        end
    end

endmodule

// File: doc/pulse_period_meter.md
PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the counter and period width in bits.
REQ-002 The block SHALL have parameter EXPECTED, default 1000000, giving the nominal period in clk cycles.
REQ-003 The block SHALL have parameter TOL, default 1000, giving the allowed +/- deviation from EXPECTED, in cycles.
REQ-004 The block SHALL have parameter TIMEOUT, default 2000000, giving the cycles without an edge before signal loss is declared; legal range is 2..2^WIDTH-1.
REQ-005 The block SHALL have parameter LOCK_N, default 4, giving the number of consecutive in-tolerance periods required for lock; legal range is 1..15.
REQ-006 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 tick_in  input  1  monitored strobe or level; each rising edge marks a period boundary.
REQ-009 clear  input  1  synchronous restart of measurement.
REQ-010 period  output  WIDTH  last measured period in clk cycles.
REQ-011 period_valid  output  1  one-cycle pulse each time period is updated.
REQ-012 locked  output  1  high while the last LOCK_N periods were all within EXPECTED+/-TOL.
REQ-013 stalled  output  1  sticky flag: a timeout occurred since the last reset or clear.

Function
REQ-014 Edge detect SHALL be registered: edge = s & ~s_prev, where s is tick_in after the input stage defined in REQ-029/REQ-030.
REQ-015 The FSM SHALL have states IDLE, MEASURE and LOST.
REQ-016 In IDLE, cnt SHALL hold 0 and no period SHALL be reported; an edge SHALL move the FSM to MEASURE with cnt <= 0.
REQ-017 In MEASURE with no edge, the FSM SHALL set cnt <= cnt+1.
REQ-018 In MEASURE on an edge, the FSM SHALL set period <= cnt+1, pulse period_valid, and set cnt <= 0 (edges 4 cycles apart give period = 4).
REQ-019 In MEASURE with cnt == TIMEOUT-1 and no edge, the FSM SHALL go to LOST, set stalled <= 1 and locked <= 0, and SHALL NOT update period.
REQ-020 If an edge coincides with cnt == TIMEOUT-1, the edge SHALL win: period = TIMEOUT is reported and the FSM stays in MEASURE.
REQ-021 In LOST, the first edge SHALL go to MEASURE with cnt <= 0 and no period report; that interval is unmeasured.
REQ-022 Lock counter good_cnt (saturating at LOCK_N) SHALL increment on each reported period in [EXPECTED-TOL, EXPECTED+TOL], inclusive.
REQ-023 An out-of-range period SHALL set good_cnt <= 0 and deassert locked on the same edge as period_valid.
REQ-024 locked SHALL be registered high on the edge where good_cnt reaches LOCK_N, which is the same edge as the qualifying period_valid.
REQ-025 Tolerance bounds SHALL be computed at WIDTH+1 bits; EXPECTED-TOL SHALL clamp at 0, so there is no wrap-around.
REQ-026 clear SHALL move the FSM to IDLE and zero cnt, period, good_cnt, locked, stalled and period_valid; clear SHALL take priority over a simultaneous edge or timeout.

Reset
REQ-027 Asserting reset SHALL immediately force IDLE and set cnt, period, good_cnt, period_valid, locked, stalled and all input/edge registers to 0, whether or not clk is running.
REQ-028 Reset asserted mid-measurement SHALL discard the partial count; the first edge after release SHALL only arm MEASURE and SHALL NOT report a period.

Configuration
REQ-029 With macro PULSE_PERIOD_METER_SYNC_EN defined, tick_in SHALL pass through a 2-flop synchronizer before s, adding 2 cycles of latency to period_valid; measured period values SHALL be unchanged.
REQ-030 Without PULSE_PERIOD_METER_SYNC_EN, s SHALL be tick_in registered once; tick_in is then required to be synchronous to clk.

Verification (bench parameters: EXPECTED=8, TOL=1, TIMEOUT=20, LOCK_N=2)
REQ-031 Bench SHALL drive one-cycle tick_in pulses every 8 clk -> first edge gives no report; then period=8 with a period_valid pulse every 8 cycles; locked rises with the 2nd reported period.
REQ-032 Bench SHALL drive a locked stream then one interval of 12 -> period=12 and locked falls on that period_valid; the next two 8s relock.
REQ-033 Bench SHALL stop tick_in after lock -> stalled=1, locked=0 exactly 20 cycles after the last edge; resumed ticks give one unreported interval, then period=8.
REQ-034 Bench SHALL place an edge exactly 20 cycles after the previous one -> period=20, stalled stays 0, FSM stays in MEASURE.
REQ-035 Bench SHALL assert clear together with an edge, and separately assert async reset mid-interval -> all outputs 0, FSM in IDLE, no period_valid, and the next edge only arms.
REQ-036 Bench SHALL repeat REQ-031 with PULSE_PERIOD_METER_SYNC_EN defined -> identical period values, with period_valid 2 cycles later.
